// File: rtl/common.sv
// Shared CBus transaction types used by every block on the cache/memory bus.
// Latency: n/a (type definitions only).
// Backpressure: n/a; the response ready bit is the per-beat handshake.
package common;

    // Request from a cache-side master. len is the burst length minus one.
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    // Per-beat response; last marks the final beat of a burst.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_scheduler_rr_pick.sv
// Round-robin first-set finder: lowest-distance requester after i_last wins.
// Latency: purely combinational.
// Backpressure: none; o_vld is low when no requester is set.
// Ports: i_req  - one request bit per requester
//        i_last - index that was served last (lowest priority)
//        o_vld  - some request is set
//        o_idx  - winning index
module rr_pick #(
    parameter int NUM_INPUTS = 2,
    parameter int IW         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [IW-1:0]         i_last,
    output logic                  o_vld,
    output logic [IW-1:0]         o_idx
);

    int w_dist;
    int w_best;

    // Distance 0 is the slot right after i_last, distance NUM_INPUTS-1 is
    // i_last itself; the smallest distance among set bits wins.
    always_comb begin
        o_vld  = 1'b0;
        o_idx  = '0;
        w_dist = 0;
        w_best = NUM_INPUTS;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_dist = (i + NUM_INPUTS - 1 - int'(i_last)) % NUM_INPUTS;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_vld  = 1'b1;
                o_idx  = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_rr_scheduler.sv
// Round-robin CBus scheduler: N cache-side requesters share one memory port.
// Latency: 1 cycle IDLE->BUSY arbitration, then oreq/iresps are combinational pass-through.
// Backpressure: non-granted ports see ready=0 until the granted burst ends or aborts.
// Ports: clk/reset (sync, active-high); ireqs/iresps per requester;
//        oreq/oresp toward memory; timeout is a sticky no-response watchdog flag.
module cbus_rr_scheduler
    import common::*;
#(
    parameter int NUM_INPUTS     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       timeout
);

    localparam int            IW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int            WW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_sel;
    logic [IW-1:0]         r_last;
    logic [WW-1:0]         r_wdog;
    logic                  r_timeout;

    logic [NUM_INPUTS-1:0] w_req_vld;
    logic                  w_pick_vld;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_grant;
    logic                  w_done;
    cbus_req_t             w_sel_req;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_req_vld[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IW         (IW)
    ) u_rr_pick (
        .i_req  (w_req_vld),
        .i_last (r_last),
        .o_vld  (w_pick_vld),
        .o_idx  (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_sel_req   = '0;
        oreq        = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            iresps[j] = '0;
        end

        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (IW'(i) == r_sel) begin
                w_sel_req = ireqs[i];
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                oreq = w_sel_req;
                for (int j = 0; j < NUM_INPUTS; j++) begin
                    if (IW'(j) == r_sel) begin
                        iresps[j] = oresp;
                    end
                end
                // A master dropping valid mid-burst is an abort: release the
                // bus but do not count it as served, so its priority is kept.
                if (!w_sel_req.valid) begin
                    w_state_nxt = S_IDLE;
                end else if (oresp.ready && oresp.last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // State is unknown until the first reset edge; keep the bus quiet.
        if (reset) begin
            oreq = '0;
            for (int j = 0; j < NUM_INPUTS; j++) begin
                iresps[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= '0;
            r_last    <= IW'(NUM_INPUTS - 1);
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_grant) begin
                r_sel <= w_pick_idx;
            end
            if (w_done) begin
                r_last <= r_sel;
            end
            if (w_grant || oresp.ready) begin
                r_wdog <= '0;
            end else if ((r_state == S_BUSY) && (r_wdog != WDOG_MAX)) begin
                r_wdog <= r_wdog + 1'b1;
            end
            // Registered from the saturated count: flag rises the cycle after.
            if (r_wdog == WDOG_MAX) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout & ~reset;

endmodule

// File: tb/tb_cbus_rr_scheduler.sv
module tb_cbus_rr_scheduler;
    import common::*;

    localparam int N = 2;
    localparam int T = 1024;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       timeout;

    cbus_rr_scheduler #(
        .NUM_INPUTS     (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ireqs   (ireqs),
        .iresps  (iresps),
        .oreq    (oreq),
        .oresp   (oresp),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, who was served last, watchdog count.
    bit m_busy = 1'b0;
    int m_sel  = 0;
    int m_last = N - 1;
    int m_wdog = 0;
    bit m_tmo  = 1'b0;

    // Observations taken at the falling edge.
    int cyc      = 0;
    bit prev_vld = 1'b0;
    bit s_tmo    = 1'b0;
    bit s_done [N];
    int g_port [$];
    int g_cyc  [$];
    int bcnt   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_next();
        for (int k = 1; k <= N; k++) begin
            if (ireqs[(m_last + k) % N].valid) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        if (reset) begin
            m_busy = 1'b0; m_sel = 0; m_last = N - 1; m_wdog = 0; m_tmo = 1'b0;
            return;
        end
        if (m_wdog >= T) m_tmo = 1'b1;
        if (!m_busy) begin
            g = rr_next();
            if (g >= 0) begin
                m_busy = 1'b1; m_sel = g; m_wdog = 0;
            end else if (oresp.ready) begin
                m_wdog = 0;
            end
        end else begin
            if (oresp.ready) m_wdog = 0;
            else if (m_wdog < T) m_wdog = m_wdog + 1;
            if (!ireqs[m_sel].valid) begin
                m_busy = 1'b0;
            end else if (oresp.ready && oresp.last) begin
                m_last = m_sel;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        cbus_req_t  e_req;
        cbus_resp_t e_resp [N];
        @(negedge clk);
        e_req = '0;
        for (int j = 0; j < N; j++) e_resp[j] = '0;
        if (!reset && m_busy) begin
            e_req          = ireqs[m_sel];
            e_resp[m_sel]  = oresp;
        end
        check_eq("oreq", 128'(oreq), 128'(e_req));
        for (int j = 0; j < N; j++)
            check_eq($sformatf("iresps[%0d]", j), 128'(iresps[j]), 128'(e_resp[j]));
        check_eq("timeout", 128'(timeout), 128'(!reset && m_tmo));
        if (oreq.valid && !prev_vld) begin
            g_port.push_back(int'(oreq.addr[0]));
            g_cyc.push_back(cyc);
        end
        prev_vld = oreq.valid;
        s_tmo    = timeout;
        for (int j = 0; j < N; j++) s_done[j] = iresps[j].ready && iresps[j].last;
        cyc++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        bit was;
        was = m_busy;
        cycle();
        if (was && m_busy) bcnt++;
        else bcnt = 0;
    endtask

    // Memory answers every beat once 'pre' BUSY cycles have passed, and
    // marks last according to the granted request's burst length.
    task automatic drive_mem(input int pre);
        oresp = '0;
        if (m_busy && bcnt >= pre) begin
            oresp.ready = 1'b1;
            oresp.data  = $urandom;
            oresp.last  = ((bcnt - pre) == int'(ireqs[m_sel].len));
        end
    endtask

    task automatic set_req(input int p, input bit v, input int len);
        ireqs[p]       = '0;
        ireqs[p].valid = v;
        ireqs[p].addr  = 32'(p);
        ireqs[p].len   = 4'(len);
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        oresp = '0;
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 0);
        tick();
        reset = 1'b0;
        g_port.delete();
        g_cyc.delete();
    endtask

    initial begin
        int t_cyc;
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 0);
        oresp = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Both ports always requesting single beats: strict alternation.
        g_port.delete(); g_cyc.delete();
        set_req(0, 1'b1, 0);
        set_req(1, 1'b1, 0);
        for (int k = 0; k < 40 && g_port.size() < 4; k++) begin
            drive_mem(1);
            tick();
        end
        check_eq("alt_grants", 128'(g_port.size()), 128'(4));
        if (g_port.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("alt_order%0d", k), 128'(g_port[k]), 128'(k % 2));
                if (k > 0) check_eq("alt_gap", 128'(g_cyc[k] - g_cyc[k-1]), 128'(3));
            end
        end

        // Port 1 four-beat burst, port 0 arrives mid-burst and must wait.
        reset_cycle();
        set_req(1, 1'b1, 3);
        for (int k = 0; k < 40 && g_port.size() < 2; k++) begin
            if (m_busy && m_sel == 1 && bcnt == 1) set_req(0, 1'b1, 0);
            drive_mem(0);
            tick();
            if (s_done[1]) set_req(1, 1'b0, 0);
        end
        check_eq("burst_grants", 128'(g_port.size()), 128'(2));
        if (g_port.size() >= 2) begin
            check_eq("burst_first", 128'(g_port[0]), 128'(1));
            check_eq("burst_second", 128'(g_port[1]), 128'(0));
            check_eq("burst_gap", 128'(g_cyc[1] - g_cyc[0]), 128'(5));
        end

        // Port 0 alone, back-to-back single beats.
        reset_cycle();
        set_req(0, 1'b1, 0);
        for (int k = 0; k < 40 && g_port.size() < 3; k++) begin
            drive_mem(0);
            tick();
        end
        check_eq("solo_grants", 128'(g_port.size()), 128'(3));
        if (g_port.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check_eq($sformatf("solo_port%0d", k), 128'(g_port[k]), 128'(0));
                if (k > 0) check_eq("solo_gap", 128'(g_cyc[k] - g_cyc[k-1]), 128'(2));
            end
        end

        // Watchdog: memory never answers.
        reset_cycle();
        set_req(0, 1'b1, 0);
        t_cyc = -1;
        for (int k = 0; k < 1100 && t_cyc < 0; k++) begin
            oresp = '0;
            tick();
            if (s_tmo) t_cyc = cyc - 1;
        end
        check_eq("tmo_seen", 128'(t_cyc >= 0), 128'(1));
        if (t_cyc >= 0 && g_cyc.size() > 0)
            check_eq("tmo_delay", 128'(t_cyc - g_cyc[0]), 128'(1025));
        for (int k = 0; k < 5; k++) tick();
        check_eq("tmo_sticky", 128'(s_tmo), 128'(1));
        reset = 1'b1;
        tick();
        check_eq("tmo_in_reset", 128'(s_tmo), 128'(0));
        reset = 1'b0;
        tick();
        check_eq("tmo_after_reset", 128'(s_tmo), 128'(0));

        // Reset in the middle of a port 1 burst.
        reset_cycle();
        set_req(1, 1'b1, 7);
        for (int k = 0; k < 10 && bcnt < 2; k++) begin
            oresp = '0;
            oresp.ready = m_busy;
            tick();
        end
        reset = 1'b1;
        oresp = '0;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 0);
        tick();
        check_eq("rst_idle", 128'(prev_vld), 128'(0));
        g_port.delete(); g_cyc.delete();
        tick();
        check_eq("rst_grants", 128'(g_port.size()), 128'(1));
        if (g_port.size() >= 1) check_eq("rst_first", 128'(g_port[0]), 128'(0));

        // Port 0 aborts while port 1 waits; port 0 keeps its priority.
        set_req(0, 1'b0, 0);
        tick();
        set_req(0, 1'b1, 0);
        tick();
        check_eq("abort_idle", 128'(prev_vld), 128'(0));
        g_port.delete(); g_cyc.delete();
        tick();
        check_eq("abort_grants", 128'(g_port.size()), 128'(1));
        if (g_port.size() >= 1) check_eq("abort_winner", 128'(g_port[0]), 128'(0));

        // Random traffic against the model.
        reset_cycle();
        for (int k = 0; k < 3000; k++) begin
            for (int p = 0; p < N; p++) begin
                if (ireqs[p].valid) begin
                    if (s_done[p] || $urandom_range(0, 40) == 0) ireqs[p].valid = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    ireqs[p].valid    = 1'b1;
                    ireqs[p].is_write = 1'($urandom);
                    ireqs[p].size     = 3'($urandom);
                    ireqs[p].addr     = $urandom;
                    ireqs[p].strobe   = 4'($urandom);
                    ireqs[p].data     = $urandom;
                    ireqs[p].len      = 4'($urandom_range(0, 3));
                end
            end
            oresp.ready = ($urandom_range(0, 3) != 0);
            oresp.last  = ($urandom_range(0, 2) == 0);
            oresp.data  = $urandom;
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cbus_rr_scheduler.md
CBUS_RR_SCHEDULER -- requirements
Module: cbus_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2, meaning number of CBus requesters (index 0 = ICache side, 1 = DCache side).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning BUSY cycles without oresp.ready before the timeout flag sets.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ireqs  input  cbus_req_t[NUM_INPUTS]  per-requester CBus requests.
REQ-006 SHALL have port iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester CBus responses.
REQ-007 SHALL have port oreq  output  cbus_req_t  request to memory/bus.
REQ-008 SHALL have port oresp  input  cbus_resp_t  response from memory/bus.
REQ-009 SHALL have port timeout  output  1  sticky watchdog flag.

Function
REQ-010 SHALL implement states IDLE and BUSY, plus registers sel (grant index), last (last completed grant) and wdog (watchdog counter).
REQ-011 In IDLE: oreq = '0 and all iresps = '0.
REQ-012 In IDLE with any ireqs[i].valid: SHALL pick the first valid index in round-robin order starting at (last+1) mod NUM_INPUTS, load sel, and enter BUSY next cycle; arbitration latency is exactly 1 cycle.
REQ-013 In IDLE with no valid request: SHALL stay in IDLE with sel and last unchanged.
REQ-014 In BUSY: oreq = ireqs[sel] combinationally, iresps[sel] = oresp, and every other iresps[j] = '0.
REQ-015 In BUSY, oresp.ready && oresp.last in the same cycle: SHALL forward that beat, set last = sel, and return to IDLE; IDLE holds at least 1 cycle between grants.
REQ-016 In BUSY, oresp.ready without oresp.last: SHALL stay BUSY; burst length follows ireqs[sel].len and the scheduler does not count beats.
REQ-017 In BUSY, ireqs[sel].valid low (protocol violation/abort): SHALL return to IDLE next cycle with last unchanged.
REQ-018 Requests arriving at non-selected ports during BUSY SHALL be held off (ready = 0) and arbitrated only at the next IDLE.
REQ-019 wdog SHALL clear on entering BUSY and on any oresp.ready, and increment each BUSY cycle otherwise, saturating at TIMEOUT_CYCLES.
REQ-020 When wdog reaches TIMEOUT_CYCLES, timeout SHALL set and stay set until reset; the FSM is unaffected.
REQ-021 With NUM_INPUTS = 1: SHALL grant port 0 every time; round-robin reduces to the identity.

Reset
REQ-022 On reset high at a clock edge: state = IDLE, sel = 0, last = NUM_INPUTS-1 (so port 0 wins first), wdog = 0, timeout = 0.
REQ-023 Outputs during and after reset: oreq = '0, all iresps = '0, timeout = 0.
REQ-024 Reset during BUSY SHALL abandon the burst without completing handshakes.

Structure
REQ-025 cbus_req_t and cbus_resp_t SHALL come from package common; no new shared typedefs.
REQ-026 A state enum local to the module SHALL be used.
REQ-027 One sub-module SHALL be used: rr_pick (combinational round-robin first-set finder over NUM_INPUTS given last).

Verification
REQ-028 Both ports valid from reset, len=0 single beats, oresp.ready+last 2 cycles after grant -> grants in order 0,1,0,1; never two in BUSY together.
REQ-029 Port 1 requests a 4-beat burst; port 0 requests mid-burst -> port 0 iresps.ready = 0 until port 1's last beat, then granted after a 1-cycle IDLE.
REQ-030 Port 0 only, 3 back-to-back requests -> granted each time; idle cycle between each.
REQ-031 Grant to port 0, oresp.ready never asserted for 1024 BUSY cycles -> timeout = 1 in the cycle after wdog reaches 1024 and remains 1; reset -> timeout = 0.
REQ-032 Reset asserted mid-burst on port 1 -> next cycle oreq.valid = 0 and state IDLE; with both ports then valid, port 0 is granted first.
REQ-033 Port 0 drops valid in BUSY -> IDLE next cycle; last unchanged, so port 0 regains priority over port 1 if last was 1.
